// File: rtl/aao_pkg.sv
// Shared types and constants for the AND_AND_OR sampling controller.
package aao_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Galois feedback taps applied when the bit shifted out is 1.
    localparam logic [31:0] LFSR_MASK    = 32'h80200003;
    // Power-on seed, also substituted for an all-zero seed load.
    localparam logic [31:0] AAO_SEED_DEF = 32'hACE12468;

endpackage

// File: rtl/AND_AND_OR.sv
// Library cell: Y = (A1 | A2) & B.
module AND_AND_OR (
    input  logic A1,
    input  logic A2,
    input  logic B,
    output logic Y
);

    assign Y = (A1 | A2) & B;

endmodule

// File: rtl/aao_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous reset and parallel load.
module aao_lfsr32
    import aao_pkg::*;
#(
    parameter logic [31:0] SEED = AAO_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic [31:0] q
);

    logic [31:0] q_q, q_d;

    // Load wins over advance; taps are folded in when a 1 shifts out of bit 0.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = {1'b0, q_q[31:1]} ^ (q_q[0] ? LFSR_MASK : 32'h0);
        end
    end

    // State register; reset restores the seed.
    always_ff @(posedge clk) begin
        if (rst) q_q <= SEED;
        else     q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/aao_sample_ctrl.sv
// Runs N random samples of (a1|a2)&b through the AND_AND_OR cell and counts ones.
module aao_sample_ctrl
    import aao_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] SEED_DEF = AAO_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic [7:0]       p_a1,
    input  logic [7:0]       p_a2,
    input  logic [7:0]       p_b,
    input  logic             seed_load,
    input  logic [31:0]      seed,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] ones_count,
    output logic             a1_s,
    output logic             a2_s,
    output logic             b_s,
    output logic             y_s
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [7:0]       pa1_q, pa1_d, pa2_q, pa2_d, pb_q, pb_d;

    logic        idle, lfsr_en, lfsr_load;
    logic [31:0] lfsr, lfsr_ld_val;
    logic        a1, a2, b, y;
    logic        unused_lfsr_hi;

    assign idle = (state_q == ST_IDLE);

    // Seed loads are only honoured while idle; a zero seed would lock up the LFSR.
    assign lfsr_load   = idle & seed_load;
    assign lfsr_ld_val = (seed == 32'h0) ? SEED_DEF : seed;

    aao_lfsr32 #(.SEED(SEED_DEF)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (lfsr_en),
        .load     (lfsr_load),
        .load_val (lfsr_ld_val),
        .q        (lfsr)
    );

    // Top byte of the LFSR does not feed any comparator.
    assign unused_lfsr_hi = ^lfsr[31:24];

    assign a1 = (lfsr[7:0]   < pa1_q);
    assign a2 = (lfsr[15:8]  < pa2_q);
    assign b  = (lfsr[23:16] < pb_q);

    AND_AND_OR u_gate (
        .A1 (a1),
        .A2 (a2),
        .B  (b),
        .Y  (y)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; a zero-length run skips straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = (n_samples != '0) ? ST_RUN : ST_DONE;
            ST_RUN:  if (cnt_q == n_q - ONE) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs; sample bits are gated to 0 outside RUN.
    always_comb begin
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        lfsr_en = busy;
        a1_s    = busy & a1;
        a2_s    = busy & a2;
        b_s     = busy & b;
        y_s     = busy & y;
    end

    // Datapath next state: capture run parameters on start, count while running.
    always_comb begin
        n_d    = n_q;
        pa1_d  = pa1_q;
        pa2_d  = pa2_q;
        pb_d   = pb_q;
        cnt_d  = cnt_q;
        ones_d = ones_q;
        if (idle && start) begin
            n_d    = n_samples;
            pa1_d  = p_a1;
            pa2_d  = p_a2;
            pb_d   = p_b;
            cnt_d  = '0;
            ones_d = '0;
        end else if (busy) begin
            cnt_d  = cnt_q + ONE;
            ones_d = ones_q + {{(CNT_W-1){1'b0}}, y_s};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q    <= '0;
            pa1_q  <= '0;
            pa2_q  <= '0;
            pb_q   <= '0;
            cnt_q  <= '0;
            ones_q <= '0;
        end else begin
            n_q    <= n_d;
            pa1_q  <= pa1_d;
            pa2_q  <= pa2_d;
            pb_q   <= pb_d;
            cnt_q  <= cnt_d;
            ones_q <= ones_d;
        end
    end

    assign ones_count = ones_q;

endmodule

// File: tb/tb_aao_sample_ctrl.sv
// Directed bench for aao_sample_ctrl with an independent Galois LFSR model.
module tb_aao_sample_ctrl;

    localparam int          CNT_W    = 16;
    localparam logic [31:0] SEED_DEF = 32'hACE12468;
    localparam logic [31:0] TAPS     = 32'h80200003;

    logic             clk = 1'b0;
    logic             rst, start, seed_load;
    logic [CNT_W-1:0] n_samples;
    logic [7:0]       p_a1, p_a2, p_b;
    logic [31:0]      seed;
    logic             busy, done, a1_s, a2_s, b_s, y_s;
    logic [CNT_W-1:0] ones_count;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] m;            // expected LFSR state

    always #5 clk = ~clk;

    aao_sample_ctrl #(.CNT_W(CNT_W), .SEED_DEF(SEED_DEF)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_samples  (n_samples),
        .p_a1       (p_a1),
        .p_a2       (p_a2),
        .p_b        (p_b),
        .seed_load  (seed_load),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .ones_count (ones_count),
        .a1_s       (a1_s),
        .a2_s       (a2_s),
        .b_s        (b_s),
        .y_s        (y_s)
    );

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        logic [31:0] r;
        r = x >> 1;
        if (x[0]) r = r ^ TAPS;
        return r;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m = SEED_DEF;
    endtask

    // Launch one run and observe cycles 1..n+3 after the accepting edge.
    task automatic do_run(input int n, input logic [7:0] pa1, input logic [7:0] pa2,
                          input logic [7:0] pb, input bit spam,
                          output int done_at, output int done_cnt, output int busy_cnt,
                          output int bit_err, output int y_hi, output int exp_ones);
        logic ea1, ea2, eb, ey;
        n_samples = CNT_W'(n);
        p_a1 = pa1; p_a2 = pa2; p_b = pb;
        start = 1'b1;
        @(posedge clk); #1;
        start = spam;
        seed_load = 1'b0;
        done_at = -1; done_cnt = 0; busy_cnt = 0; bit_err = 0; y_hi = 0; exp_ones = 0;
        for (int i = 1; i <= n + 3; i++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (y_s === 1'b1) y_hi++;
            end
            if (i <= n) begin
                ea1 = (m[7:0]   < pa1);
                ea2 = (m[15:8]  < pa2);
                eb  = (m[23:16] < pb);
                ey  = (ea1 | ea2) & eb;
                if ({a1_s, a2_s, b_s, y_s} !== {ea1, ea2, eb, ey}) bit_err++;
                if (ey) exp_ones++;
                m = lfsr_step(m);
            end else if ({a1_s, a2_s, b_s, y_s} !== 4'b0) begin
                bit_err++;
            end
            if (spam && i <= n) begin
                p_a1 = 8'($urandom); p_a2 = 8'($urandom); p_b = 8'($urandom);
                n_samples = CNT_W'($urandom);
                seed_load = 1'b1; seed = $urandom;
            end
            if (i == n + 1) begin
                start = 1'b0;
                seed_load = 1'b0;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; seed_load = 1'b0; seed = '0;
        n_samples = '0; p_a1 = '0; p_a2 = '0; p_b = '0;
        repeat (3) @(posedge clk);
        #1;
        if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b want 0", busy); miscompares++; end
        vectors++;
        if (done !== 1'b0) begin $display("FAIL reset_done: got %b want 0", done); miscompares++; end
        vectors++;
        if (ones_count !== '0) begin $display("FAIL reset_ones: got %0d want 0", ones_count); miscompares++; end
        vectors++;
        if ({a1_s, a2_s, b_s, y_s} !== 4'b0) begin
            $display("FAIL reset_bits: got %b want 0000", {a1_s, a2_s, b_s, y_s}); miscompares++;
        end
        vectors++;
        rst = 1'b0;
        m = SEED_DEF;
    endtask

    task automatic test_p_zero();
        int da, dc, bc, be, yh, eo;
        do_run(500, 8'd0, 8'd0, 8'd255, 1'b0, da, dc, bc, be, yh, eo);
        if (da !== 501) begin $display("FAIL pzero_done_cycle: got %0d want 501", da); miscompares++; end
        vectors++;
        if (yh !== 0) begin $display("FAIL pzero_y_high: got %0d want 0", yh); miscompares++; end
        vectors++;
        if (ones_count !== '0) begin $display("FAIL pzero_ones: got %0d want 0", ones_count); miscompares++; end
        vectors++;
        if (be !== 0) begin $display("FAIL pzero_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
    endtask

    task automatic test_all_ones();
        int da, dc, bc, be, yh, eo;
        apply_reset();
        do_run(1000, 8'd255, 8'd255, 8'd255, 1'b0, da, dc, bc, be, yh, eo);
        if (da !== 1001) begin $display("FAIL ones_done_cycle: got %0d want 1001", da); miscompares++; end
        vectors++;
        if (bc !== 1000) begin $display("FAIL ones_busy_cycles: got %0d want 1000", bc); miscompares++; end
        vectors++;
        if (be !== 0) begin $display("FAIL ones_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
        if (int'(ones_count) !== eo) begin $display("FAIL ones_count_model: got %0d want %0d", ones_count, eo); miscompares++; end
        vectors++;
        if (ones_count < 980) begin $display("FAIL ones_count_min: got %0d want >=980", ones_count); miscompares++; end
        vectors++;
    endtask

    task automatic test_zero_n();
        int da, dc, bc, be, yh, eo;
        do_run(0, 8'd77, 8'd200, 8'd33, 1'b0, da, dc, bc, be, yh, eo);
        if (da !== 1) begin $display("FAIL zero_done_cycle: got %0d want 1", da); miscompares++; end
        vectors++;
        if (dc !== 1) begin $display("FAIL zero_done_pulses: got %0d want 1", dc); miscompares++; end
        vectors++;
        if (bc !== 0) begin $display("FAIL zero_busy: got %0d cycles want 0", bc); miscompares++; end
        vectors++;
        if (ones_count !== '0) begin $display("FAIL zero_ones: got %0d want 0", ones_count); miscompares++; end
        vectors++;
    endtask

    task automatic test_back_to_back();
        int da, dc, bc, be, yh, eo;
        do_run(10, 8'd90, 8'd160, 8'd200, 1'b1, da, dc, bc, be, yh, eo);
        if (dc !== 1) begin $display("FAIL b2b_done_pulses: got %0d want 1", dc); miscompares++; end
        vectors++;
        if (da !== 11) begin $display("FAIL b2b_done_cycle: got %0d want 11", da); miscompares++; end
        vectors++;
        if (bc !== 10) begin $display("FAIL b2b_busy_cycles: got %0d want 10", bc); miscompares++; end
        vectors++;
        if (be !== 0) begin $display("FAIL b2b_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
        if (int'(ones_count) !== eo) begin $display("FAIL b2b_ones: got %0d want %0d", ones_count, eo); miscompares++; end
        vectors++;
    endtask

    task automatic test_reset_mid();
        int da, dc, bc, be, yh, eo, ref_ones, late_done;
        apply_reset();
        do_run(100, 8'd200, 8'd100, 8'd180, 1'b0, da, dc, bc, be, yh, eo);
        ref_ones = eo;
        if (int'(ones_count) !== eo) begin $display("FAIL rmid_first_ones: got %0d want %0d", ones_count, eo); miscompares++; end
        vectors++;
        apply_reset();
        n_samples = CNT_W'(100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m = SEED_DEF;
        if (busy !== 1'b0) begin $display("FAIL rmid_busy: got %b want 0", busy); miscompares++; end
        vectors++;
        if (ones_count !== '0) begin $display("FAIL rmid_ones: got %0d want 0", ones_count); miscompares++; end
        vectors++;
        late_done = (done === 1'b1) ? 1 : 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done === 1'b1) late_done++;
        end
        if (late_done !== 0) begin $display("FAIL rmid_no_done: got %0d pulses want 0", late_done); miscompares++; end
        vectors++;
        do_run(100, 8'd200, 8'd100, 8'd180, 1'b0, da, dc, bc, be, yh, eo);
        if (int'(ones_count) !== ref_ones) begin $display("FAIL rmid_rerun_ones: got %0d want %0d", ones_count, ref_ones); miscompares++; end
        vectors++;
        if (be !== 0) begin $display("FAIL rmid_rerun_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
    endtask

    task automatic test_seed();
        int da, dc, bc, be, yh, eo;
        seed = 32'h0; seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m = SEED_DEF;
        do_run(200, 8'd128, 8'd128, 8'd128, 1'b0, da, dc, bc, be, yh, eo);
        if (be !== 0) begin $display("FAIL seed0_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
        if (int'(ones_count) !== eo) begin $display("FAIL seed0_ones: got %0d want %0d", ones_count, eo); miscompares++; end
        vectors++;
        // Seed load in the same cycle as start: the run must use the new seed.
        seed = 32'h1; seed_load = 1'b1;
        m = 32'h1;
        do_run(200, 8'd128, 8'd128, 8'd128, 1'b0, da, dc, bc, be, yh, eo);
        if (be !== 0) begin $display("FAIL seed1_bits: got %0d bad cycles want 0", be); miscompares++; end
        vectors++;
        if (int'(ones_count) !== eo) begin $display("FAIL seed1_ones: got %0d want %0d", ones_count, eo); miscompares++; end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_p_zero();
        test_all_ones();
        test_zero_n();
        test_back_to_back();
        test_reset_mid();
        test_seed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
